// File: rtl/spi_flash_seq.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_seq
// Description : Wishbone byte master that drives an 8-bit SPI master
//               peripheral (0 SPCR, 1 SPSR, 2 data FIFO, 3 SPER, 4 SS) to
//               perform a complete flash read: chip-select, opcode, 24-bit
//               address, then len_i dummy-clocked data bytes. Received data
//               bytes leave on a valid/ready byte stream.
// Ports       : clk_i/rst_i        clock, async active-high reset
//               start_i ... cs_sel_i  transaction request and its arguments
//               busy_o/done_o/err_o   transaction status
//               rd_data_o/rd_valid_o/rd_ready_i  received byte stream
//               m_*                Wishbone master towards the SPI peripheral
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_seq #(
    parameter int         SS_WIDTH = 2,
    parameter int         LEN_W    = 16,
    parameter logic [7:0] SPCR_VAL = 8'h50,
    parameter logic [7:0] SPER_VAL = 8'h00,
    parameter int         POLL_MAX = 1023
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [7:0]          cmd_i,
    input  logic [23:0]         addr_i,
    input  logic [LEN_W-1:0]    len_i,
    input  logic [SS_WIDTH-1:0] cs_sel_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [7:0]          rd_data_o,
    output logic                rd_valid_o,
    input  logic                rd_ready_i,
    output logic                m_cyc_o,
    output logic                m_stb_o,
    output logic [2:0]          m_adr_o,
    output logic                m_we_o,
    output logic [7:0]          m_dat_o,
    input  logic [7:0]          m_dat_i,
    input  logic                m_ack_i
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_W_SPCR  = 4'd1,
        S_W_SPER  = 4'd2,
        S_W_SS    = 4'd3,
        S_TX      = 4'd4,
        S_POLL    = 4'd5,
        S_RX      = 4'd6,
        S_OUT     = 4'd7,
        S_W_SSOFF = 4'd8,
        S_FIN     = 4'd9
    } state_t;

    // Poll counter holds the number of SPSR reads already seen with rfempty=1
    localparam int            c_pw        = (POLL_MAX < 2) ? 1 : $clog2(POLL_MAX);
    localparam logic [c_pw-1:0] c_poll_last = c_pw'(POLL_MAX - 1);

    state_t                r_state;
    logic [7:0]            r_cmd;
    logic [23:0]           r_addr;
    logic [SS_WIDTH-1:0]   r_cs;
    logic [LEN_W:0]        r_remain;   // one spare bit so an all-ones len never wraps
    logic [2:0]            r_idx;      // 0..3 header byte index, 4 = data phase
    logic [c_pw-1:0]       r_poll;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic [7:0]            r_rd_data;
    logic                  r_rd_valid;
    logic                  r_cyc;
    logic [2:0]            r_adr;
    logic                  r_we;
    logic [7:0]            r_dat;

    logic [7:0]            w_tx_byte;
    logic [7:0]            w_ss_on;
    logic [2:0]            w_adr;
    logic                  w_we;
    logic [7:0]            w_dat;

    assign w_ss_on = 8'(r_cs);

    always_comb begin
        w_tx_byte = 8'h00;
        case (r_idx)
            3'd0:    w_tx_byte = r_cmd;
            3'd1:    w_tx_byte = r_addr[23:16];
            3'd2:    w_tx_byte = r_addr[15:8];
            3'd3:    w_tx_byte = r_addr[7:0];
            default: w_tx_byte = 8'h00;
        endcase
    end

    // Access launched by each bus state when it finds the bus idle
    always_comb begin
        w_adr = 3'd0;
        w_we  = 1'b0;
        w_dat = 8'h00;
        case (r_state)
            S_W_SPCR:  begin w_adr = 3'd0; w_we = 1'b1; w_dat = SPCR_VAL;  end
            S_W_SPER:  begin w_adr = 3'd3; w_we = 1'b1; w_dat = SPER_VAL;  end
            S_W_SS:    begin w_adr = 3'd4; w_we = 1'b1; w_dat = w_ss_on;   end
            S_TX:      begin w_adr = 3'd2; w_we = 1'b1; w_dat = w_tx_byte; end
            S_POLL:    begin w_adr = 3'd1; w_we = 1'b0; w_dat = 8'h00;     end
            S_RX:      begin w_adr = 3'd2; w_we = 1'b0; w_dat = 8'h00;     end
            S_W_SSOFF: begin w_adr = 3'd4; w_we = 1'b1; w_dat = 8'h00;     end
            default:   begin w_adr = 3'd0; w_we = 1'b0; w_dat = 8'h00;     end
        endcase
    end

    // Each bus state: first cycle with cyc low launches the access, the ack
    // edge drops cyc and moves on. The next state therefore always starts
    // with one idle cycle, which the peripheral's toggling ack requires.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_cmd      <= 8'h00;
            r_addr     <= 24'h0;
            r_cs       <= '0;
            r_remain   <= '0;
            r_idx      <= 3'd0;
            r_poll     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rd_data  <= 8'h00;
            r_rd_valid <= 1'b0;
            r_cyc      <= 1'b0;
            r_adr      <= 3'd0;
            r_we       <= 1'b0;
            r_dat      <= 8'h00;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_cmd    <= cmd_i;
                        r_addr   <= addr_i;
                        r_cs     <= cs_sel_i;
                        r_remain <= {1'b0, len_i};
                        r_idx    <= 3'd0;
                        r_err    <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_W_SPCR;
                    end
                end
                S_W_SPCR, S_W_SPER, S_W_SS, S_TX, S_POLL, S_RX, S_W_SSOFF: begin
                    if (!r_cyc) begin
                        r_cyc <= 1'b1;
                        r_adr <= w_adr;
                        r_we  <= w_we;
                        r_dat <= w_dat;
                    end else if (m_ack_i) begin
                        r_cyc <= 1'b0;
                        case (r_state)
                            S_W_SPCR: r_state <= S_W_SPER;
                            S_W_SPER: r_state <= S_W_SS;
                            S_W_SS:   r_state <= S_TX;
                            S_TX: begin
                                r_poll  <= '0;
                                r_state <= S_POLL;
                            end
                            S_POLL: begin
                                if (!m_dat_i[0]) begin
                                    r_state <= S_RX;
                                end else if (r_poll == c_poll_last) begin
                                    r_err   <= 1'b1;
                                    r_state <= S_W_SSOFF;
                                end else begin
                                    r_poll <= r_poll + 1'b1;
                                end
                            end
                            S_RX: begin
                                if (r_idx == 3'd4) begin
                                    r_rd_data  <= m_dat_i;
                                    r_rd_valid <= 1'b1;
                                    r_state    <= S_OUT;
                                end else begin
                                    // Header echo bytes are dropped
                                    r_idx <= r_idx + 3'd1;
                                    if (r_idx == 3'd3 && r_remain == '0) begin
                                        r_state <= S_W_SSOFF;
                                    end else begin
                                        r_state <= S_TX;
                                    end
                                end
                            end
                            S_W_SSOFF: begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_FIN;
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end
                end
                S_OUT: begin
                    // The OUT wait already separates accesses, so the next
                    // write is launched straight from the handshake cycle.
                    if (rd_ready_i) begin
                        r_rd_valid <= 1'b0;
                        r_remain   <= r_remain - 1'b1;
                        r_cyc      <= 1'b1;
                        r_we       <= 1'b1;
                        r_dat      <= 8'h00;
                        if (r_remain == (LEN_W+1)'(1)) begin
                            r_adr   <= 3'd4;
                            r_state <= S_W_SSOFF;
                        end else begin
                            r_adr   <= 3'd2;
                            r_state <= S_TX;
                        end
                    end
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign err_o      = r_err;
    assign rd_data_o  = r_rd_data;
    assign rd_valid_o = r_rd_valid;
    assign m_cyc_o    = r_cyc;
    assign m_stb_o    = r_cyc;
    assign m_adr_o    = r_adr;
    assign m_we_o     = r_we;
    assign m_dat_o    = r_dat;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_flash_seq
// Description : Self-checking bench for spi_flash_seq with a combined SPI
//               peripheral / flash model on the Wishbone side and a
//               transaction-level reference of the expected register writes
//               and returned byte stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_flash_seq;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [7:0]  cmd_i = 8'h00;
    logic [23:0] addr_i = 24'h0;
    logic [15:0] len_i = 16'h0;
    logic [1:0]  cs_sel_i = 2'b00;
    logic        busy_o, done_o, err_o;
    logic [7:0]  rd_data_o;
    logic        rd_valid_o;
    logic        rd_ready_i = 1'b0;
    logic        m_cyc_o, m_stb_o, m_we_o;
    logic [2:0]  m_adr_o;
    logic [7:0]  m_dat_o;
    logic [7:0]  m_dat_i = 8'h00;
    logic        m_ack_i = 1'b0;

    int checks = 0;
    int errors = 0;

    spi_flash_seq #(
        .SS_WIDTH(2), .LEN_W(16), .SPCR_VAL(8'h50), .SPER_VAL(8'h00), .POLL_MAX(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .cmd_i(cmd_i),
        .addr_i(addr_i), .len_i(len_i), .cs_sel_i(cs_sel_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_adr_o(m_adr_o), .m_we_o(m_we_o),
        .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- SPI peripheral + flash model ----------------
    logic [10:0] wr_q[$];      // {adr, dat} of every acked write
    logic [7:0]  miso_q[$];    // flash bytes for the data phase
    logic [7:0]  got_q[$];     // bytes accepted on the stream
    int          rd1_cnt = 0, rd2_cnt = 0, done_cnt = 0;
    int          wdly = 0, sess_idx = 0, lat_left = 0;
    bit          rx_full = 0, never_ready = 0;
    logic [7:0]  rxb = 8'h00, junk = 8'h00;
    int          rdy_mode = 0;  // 0 always ready, 1 random, 2 hold low

    always @(posedge clk_i) begin
        m_ack_i <= 1'b0;
        if (rst_i) begin
            wdly = 0; rx_full = 0; lat_left = 0;
        end else if (m_cyc_o && m_stb_o && !m_ack_i) begin
            if (wdly > 0) begin
                wdly = wdly - 1;
            end else begin
                m_ack_i <= 1'b1;
                wdly = $urandom_range(0, 2);
                junk = 8'($urandom);
                if (m_we_o) begin
                    wr_q.push_back({m_adr_o, m_dat_o});
                    if (m_adr_o == 3'd4 && m_dat_o != 8'h00) sess_idx = 0;
                    if (m_adr_o == 3'd2) begin
                        if (sess_idx < 4)            rxb = 8'hFF;
                        else if (miso_q.size() > 0)  rxb = miso_q.pop_front();
                        else                         rxb = 8'hEE;
                        sess_idx++;
                        rx_full  = 1;
                        lat_left = $urandom_range(0, 5);
                    end
                end else if (m_adr_o == 3'd1) begin
                    rd1_cnt++;
                    m_dat_i <= {junk[7:1], ~(rx_full && lat_left == 0 && !never_ready)};
                    if (lat_left > 0) lat_left = lat_left - 1;
                end else if (m_adr_o == 3'd2) begin
                    rd2_cnt++;
                    m_dat_i <= rxb;
                    rx_full = 0;
                end else begin
                    m_dat_i <= junk;
                end
            end
        end
    end

    always @(posedge clk_i) begin
        #2;
        case (rdy_mode)
            0:       rd_ready_i = 1'b1;
            1:       rd_ready_i = 1'($urandom_range(0, 1));
            default: rd_ready_i = 1'b0;
        endcase
    end

    // ---------------- protocol / stream monitors ----------------
    logic       p_cyc = 0, p_ack = 0, p_we = 0, p_valid = 0, p_ready = 0;
    logic [2:0] p_adr = 0;
    logic [7:0] p_dat = 0, p_data = 0;

    always @(negedge clk_i) begin
        if (rst_i) begin
            p_cyc = 0; p_ack = 0; p_valid = 0; p_ready = 0;
        end else begin
            if (m_cyc_o || m_stb_o) chk("stb_eq_cyc", 32'(m_stb_o), 32'(m_cyc_o));
            if (p_cyc && p_ack)
                chk("cyc_drop_after_ack", 32'(m_cyc_o), 32'(0));
            else if (p_cyc && m_cyc_o)
                chk("bus_hold", 32'({m_adr_o, m_we_o, m_dat_o}), 32'({p_adr, p_we, p_dat}));
            if (p_valid && !p_ready) begin
                chk("valid_hold", 32'(rd_valid_o), 32'(1));
                chk("data_hold", 32'(rd_data_o), 32'(p_data));
            end
            if (rd_valid_o)
                chk("no_tx_while_out", 32'(m_cyc_o && m_we_o && m_adr_o == 3'd2), 32'(0));
            if (rd_valid_o && rd_ready_i) got_q.push_back(rd_data_o);
            if (done_o) begin
                done_cnt++;
                chk("busy_low_at_done", 32'(busy_o), 32'(0));
            end
            p_cyc = m_cyc_o; p_ack = m_ack_i; p_adr = m_adr_o; p_we = m_we_o;
            p_dat = m_dat_o; p_valid = rd_valid_o; p_ready = rd_ready_i; p_data = rd_data_o;
        end
    end

    // ---------------- one transaction against the reference ----------------
    task automatic run_txn(input logic [7:0] cmd, input logic [23:0] addr,
                           input logic [15:0] len, input logic [1:0] cs,
                           input bit never, input bit stall, input int glitch,
                           input int rmode, input logic [7:0] b0, input logic [7:0] b1,
                           input bit exp_err);
        logic [10:0] exp_w[$];
        logic [7:0]  exp_s[$];
        logic [7:0]  bb;
        int          cyc, n, ntx;
        bit          seen;
        wr_q.delete(); got_q.delete(); miso_q.delete();
        rd1_cnt = 0; rd2_cnt = 0; done_cnt = 0;
        never_ready = never;
        // Expected register writes: config, SS on, opcode, address MSB first,
        // one zero per data byte, SS off. A timeout stops after the opcode.
        exp_w.push_back({3'd0, 8'h50});
        exp_w.push_back({3'd3, 8'h00});
        exp_w.push_back({3'd4, 6'b0, cs});
        exp_w.push_back({3'd2, cmd});
        if (!exp_err) begin
            for (int k = 2; k >= 0; k--) exp_w.push_back({3'd2, addr[8*k +: 8]});
            for (int k = 0; k < int'(len); k++) begin
                bb = (k == 0) ? b0 : (k == 1) ? b1 : 8'($urandom);
                exp_w.push_back({3'd2, 8'h00});
                miso_q.push_back(bb);
                exp_s.push_back(bb);
            end
        end
        exp_w.push_back({3'd4, 8'h00});
        ntx = exp_err ? 1 : 4 + int'(len);
        rdy_mode = stall ? 2 : rmode;

        @(negedge clk_i);
        cmd_i = cmd; addr_i = addr; len_i = len; cs_sel_i = cs; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("busy_after_start", 32'(busy_o), 32'(1));
        chk("err_cleared", 32'(err_o), 32'(0));
        cmd_i = 8'($urandom); addr_i = 24'($urandom); len_i = 16'($urandom);
        cs_sel_i = 2'($urandom);

        cyc = 0; seen = 0;
        while (!done_o && cyc < 20000) begin
            if (glitch > 0 && cyc == glitch) begin
                start_i = 1'b1; cmd_i = ~cmd;
            end else begin
                start_i = 1'b0;
            end
            if (stall && !seen && rd_valid_o) begin
                seen = 1;
                n = wr_q.size();
                repeat (50) @(negedge clk_i);
                chk("stall_valid", 32'(rd_valid_o), 32'(1));
                chk("stall_data", 32'(rd_data_o), 32'(b0));
                chk("stall_no_bus", 32'(wr_q.size()), 32'(n));
                rdy_mode = rmode;
            end
            @(negedge clk_i);
            cyc++;
        end
        start_i = 1'b0;
        chk("done_seen", 32'(done_o), 32'(1));
        chk("err_at_done", 32'(err_o), 32'(exp_err));
        chk("busy_at_done", 32'(busy_o), 32'(0));
        @(negedge clk_i);
        chk("done_pulse", 32'(done_o), 32'(0));
        chk("err_held", 32'(err_o), 32'(exp_err));
        repeat (3) @(negedge clk_i);
        chk("done_count", 32'(done_cnt), 32'(1));
        chk("wr_count", 32'(wr_q.size()), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < wr_q.size(); i++)
            chk($sformatf("wr_seq[%0d]", i), 32'(wr_q[i]), 32'(exp_w[i]));
        chk("stream_count", 32'(got_q.size()), 32'(exp_s.size()));
        for (int i = 0; i < exp_s.size() && i < got_q.size(); i++)
            chk($sformatf("stream[%0d]", i), 32'(got_q[i]), 32'(exp_s[i]));
        chk("rx_reads", 32'(rd2_cnt), 32'(exp_err ? 0 : ntx));
        if (exp_err) chk("poll_count", 32'(rd1_cnt), 32'(8));
        else         chk("poll_min", 32'(rd1_cnt >= ntx), 32'(1));
        chk("no_valid_left", 32'(rd_valid_o), 32'(0));
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        logic [15:0] len;
        logic [1:0]  cs;
        bit          never;
        bit          stall;
        int          glitch;
        int          rmode;
        logic [7:0]  b0, b1;
        bit          exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int cyc;
        vecs[0] = '{8'h03, 24'h123456, 16'd2, 2'b01, 0, 0, 0,  0, 8'hA5, 8'h5A, 0};
        vecs[1] = '{8'h06, 24'h000000, 16'd0, 2'b10, 0, 0, 0,  0, 8'h00, 8'h00, 0};
        vecs[2] = '{8'h0B, 24'hABCDEF, 16'd3, 2'b01, 0, 1, 0,  0, 8'h3C, 8'hC3, 0};
        vecs[3] = '{8'h03, 24'h000010, 16'd1, 2'b01, 1, 0, 0,  0, 8'h11, 8'h22, 1};
        vecs[4] = '{8'h03, 24'hFFFFFF, 16'd4, 2'b10, 0, 0, 20, 1, 8'h81, 8'h18, 0};
        vecs[5] = '{8'h9F, 24'h00F00F, 16'd5, 2'b01, 0, 0, 0,  1, 8'h00, 8'hFF, 0};

        // Reset state
        repeat (2) @(negedge clk_i);
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_done", 32'(done_o), 32'(0));
        chk("rst_err", 32'(err_o), 32'(0));
        chk("rst_valid", 32'(rd_valid_o), 32'(0));
        chk("rst_data", 32'(rd_data_o), 32'(0));
        chk("rst_bus", 32'({m_cyc_o, m_stb_o, m_adr_o, m_we_o, m_dat_o}), 32'(0));
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        for (int i = 0; i < 6; i++)
            run_txn(vecs[i].cmd, vecs[i].addr, vecs[i].len, vecs[i].cs, vecs[i].never,
                    vecs[i].stall, vecs[i].glitch, vecs[i].rmode, vecs[i].b0, vecs[i].b1,
                    vecs[i].exp_err);

        for (int i = 0; i < 8; i++)
            run_txn(8'($urandom), 24'($urandom), 16'($urandom_range(0, 6)),
                    ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10, 0, 0,
                    ($urandom_range(0, 1) == 1) ? int'($urandom_range(5, 60)) : 0, 1,
                    8'($urandom), 8'($urandom), 0);

        // Reset while the third SPSR poll is outstanding
        wr_q.delete(); miso_q.delete(); rd1_cnt = 0; done_cnt = 0;
        never_ready = 1; rdy_mode = 0;
        @(negedge clk_i);
        cmd_i = 8'h03; addr_i = 24'h000100; len_i = 16'd2; cs_sel_i = 2'b01; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        cyc = 0;
        while (!(rd1_cnt == 2 && m_cyc_o && m_adr_o == 3'd1 && !m_ack_i) && cyc < 2000) begin
            @(negedge clk_i);
            cyc++;
        end
        chk("third_poll_reached", 32'(cyc < 2000), 32'(1));
        #2 rst_i = 1'b1;
        #1;
        chk("arst_cyc", 32'(m_cyc_o), 32'(0));
        chk("arst_stb", 32'(m_stb_o), 32'(0));
        chk("arst_status", 32'({busy_o, done_o, err_o, rd_valid_o}), 32'(0));
        chk("arst_outs", 32'({rd_data_o, m_adr_o, m_we_o, m_dat_o}), 32'(0));
        @(negedge clk_i);
        rst_i = 1'b0;
        never_ready = 0;
        repeat (5) @(negedge clk_i);
        chk("no_done_after_reset", 32'(done_cnt), 32'(0));
        chk("idle_after_reset", 32'(busy_o), 32'(0));
        run_txn(8'h03, 24'h000100, 16'd2, 2'b01, 0, 0, 0, 0, 8'h77, 8'h88, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/spi_flash_seq.md
Name: spi_flash_seq

Overview:
- Wishbone byte master that sits directly upstream of the 8-bit SPI master peripheral and drives its register interface. Registers: 0 SPCR, 1 SPSR, 2 data FIFO, 3 SPER, 4 slave-select.
- Turns a single start request into a complete flash read transaction: chip-select, command byte, 24-bit address, then N dummy-clocked data bytes.
- Received data bytes leave on a valid/ready byte stream.
- Used by the boot/XIP path so the CPU never has to poll the SPI peripheral itself.

Parameters:
- SS_WIDTH, 2, width of chip-select vector; must match the SPI peripheral.
- LEN_W, 16, width of the byte-count input.
- SPCR_VAL, 8'h50, value written to SPCR at transaction start (SPE=1, SPIE=0, mode 0, divide-by-2).
- SPER_VAL, 8'h00, value written to SPER at transaction start.
- POLL_MAX, 1023, maximum SPSR polls per byte before timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- start_i  in  1  one-cycle transaction request; sampled only in IDLE
- cmd_i  in  8  flash opcode (e.g. 8'h03)
- addr_i  in  24  flash byte address, sent MSB first
- len_i  in  LEN_W  number of data bytes to read; 0 = command+address only
- cs_sel_i  in  SS_WIDTH  one-hot chip select written to register 4
- busy_o  out  1  high from accepted start until done_o
- done_o  out  1  one-cycle pulse at transaction end
- err_o  out  1  poll timeout; valid in the done_o cycle, held until next start
- rd_data_o  out  8  received data byte
- rd_valid_o  out  1  rd_data_o valid
- rd_ready_i  in  1  consumer accepts byte
- m_cyc_o, m_stb_o  out  1 each  Wishbone cycle/strobe (always equal)
- m_adr_o  out  3  register address
- m_we_o  out  1  write enable
- m_dat_o  out  8  write data
- m_dat_i  in  8  read data
- m_ack_i  in  1  acknowledge

Behaviour:
- Clock and reset: clock clk_i; reset rst_i, asynchronous, active-high.
- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-transaction aborts immediately: cyc/stb drop the same cycle and no done_o is produced.
- Bus rule:
  - Every access asserts cyc/stb with adr/we/dat stable until the cycle m_ack_i=1.
  - cyc/stb deassert in the cycle after ack is sampled.
  - At least one idle cycle separates accesses, because the peripheral's ack toggles.
  - Read data is captured from m_dat_i in the ack cycle.
- Start: start_i in IDLE latches cmd/addr/len/cs_sel, clears err_o and raises busy_o. start_i when not IDLE is ignored.
- States and transitions:
  - IDLE
  - W_SPCR: write SPCR_VAL to adr 0
  - W_SPER: write SPER_VAL to adr 3
  - W_SS: write {0,cs_sel} to adr 4
  - TX: write the current byte to adr 2
  - POLL: read adr 1; repeat while bit0 (rfempty) = 1
  - RX: read adr 2
  - OUT: present byte on rd_data_o
  - W_SSOFF: write 0 to adr 4
  - FIN: done_o=1, then IDLE
- Byte sequence:
  - Index 0 = cmd, 1..3 = addr[23:16], addr[15:8], addr[7:0], then len bytes of 8'h00.
  - Every TX byte is followed by POLL and RX so the receive FIFO never accumulates. Header RX bytes are discarded (RX→TX or, after the last byte, →W_SSOFF).
  - Data-phase RX bytes go to OUT.
- OUT: rd_valid_o=1 with rd_data_o stable until rd_ready_i. The handshake completes in the cycle valid&ready. The next TX starts the following cycle, so the SPI clock is simply stalled under backpressure.
- Counters:
  - Byte counter is LEN_W+1 bits wide and counts down remaining data bytes. len_i = max (all ones) must read exactly 2^LEN_W-1 bytes with no wrap.
  - Poll counter resets on entry to POLL. When it reaches POLL_MAX without rfempty=0: err_o=1, go to W_SSOFF, then FIN. No rd_valid_o occurs for the aborted byte.
- busy_o falls in the same cycle done_o pulses. A start_i in the cycle after FIN is accepted.

Test Plan:
- Reset, then start cmd=03 addr=0x123456 len=2 with a flash model returning A5,5A:
  - Bus sees writes adr0=50, adr3=00, adr4=01, then data writes 03,12,34,56,00,00 each followed by SPSR polls and an adr2 read.
  - Stream delivers A5 then 5A; adr4=00; one done_o; err_o=0.
- len=0, cmd=06: exactly 4 data writes, no rd_valid_o, SS asserted then released, done_o once.
- rd_ready_i held low 50 cycles on the first data byte: rd_valid_o and rd_data_o stay stable, no bus write to adr2 until the handshake, and the second byte is still correct.
- Peripheral model never clears rfempty, POLL_MAX=8: after the 8th poll read, adr4 is written 00, done_o and err_o are 1, and busy_o drops.
- Assert rst_i while the third SPSR poll is pending: cyc/stb go 0 asynchronously, all outputs 0; a new start then completes normally.
- start_i pulsed while busy with a different cmd: ignored, and the bus sequence matches the original cmd.
